array_mem_a: RTL and testbench

- Operand-A storage for the 4x4 systolic array: 64 x 16-bit register-file memory.
- One synchronous write port and four independent combinational read ports.
- Each read port feeds one row input of the array.
- Host/loader writes operands one word per cycle; the array-side sequencer drives the four read addresses every cycle.

---
 rtl/array_mem_a.sv | 87 ++++++++
 tb/tb_array_mem_a.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/array_mem_a.sv
// ============================================================================
// array_mem_a : 64 x 16 operand-A register file, 1 write / 4 combinational read
// Optional ARRAY_MEM_A_WR_BYPASS_EN forwards same-cycle write data to readers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module array_mem_a #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr_0,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [ADDR_W-1:0] read_addr_3,
  output logic [DATA_W-1:0] read_data_0,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] read_data_3
);

  localparam int NPORTS = 4;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] w_raddr [NPORTS];
  logic [DATA_W-1:0] w_rdata [NPORTS];
  logic              w_wr_in_range;

  assign w_wr_in_range = ({1'b0, write_addr} < (ADDR_W+1)'(DEPTH));

  // Per-word flops: each word owns its reset value (its own index) and decode.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(i);
    logic w_sel;
    assign w_sel = w_en && (write_addr == ADDR_W'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[i] <= RST_VAL;
      end else if (w_sel) begin
        mem_q[i] <= write_data;
      end
    end
  end

  assign w_raddr[0] = read_addr_0;
  assign w_raddr[1] = read_addr_1;
  assign w_raddr[2] = read_addr_2;
  assign w_raddr[3] = read_addr_3;

  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    logic w_rd_in_range;
    assign w_rd_in_range = ({1'b0, w_raddr[k]} < (ADDR_W+1)'(DEPTH));

    always_comb begin
      w_rdata[k] = '0;
      if (w_rd_in_range) begin
        w_rdata[k] = mem_q[w_raddr[k]];
      end
`ifdef ARRAY_MEM_A_WR_BYPASS_EN
      if (!rst && w_en && w_wr_in_range && (w_raddr[k] == write_addr)) begin
        w_rdata[k] = write_data;
      end
`endif
    end
  end

`ifndef ARRAY_MEM_A_WR_BYPASS_EN
  // Range flag only feeds the forwarding path.
  logic w_unused;
  assign w_unused = w_wr_in_range;
`endif

  assign read_data_0 = w_rdata[0];
  assign read_data_1 = w_rdata[1];
  assign read_data_2 = w_rdata[2];
  assign read_data_3 = w_rdata[3];

endmodule

`default_nettype wire

// File: tb/tb_array_mem_a.sv
// Self-checking bench for array_mem_a: directed plan plus randomized traffic
// against an array-based reference model.
`default_nettype none

module tb_array_mem_a;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_en = 1'b0;
  logic [5:0]  write_addr = '0;
  logic [15:0] write_data = '0;
  logic [5:0]  ra [4];
  logic [15:0] rd [4];

  int checks   = 0;
  int failures = 0;
  logic [15:0] ref_mem [64];

  array_mem_a dut (
    .clk        (clk),
    .rst        (rst),
    .w_en       (w_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr_0(ra[0]),
    .read_addr_1(ra[1]),
    .read_addr_2(ra[2]),
    .read_addr_3(ra[3]),
    .read_data_0(rd[0]),
    .read_data_1(rd[1]),
    .read_data_2(rd[2]),
    .read_data_3(rd[3])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [5:0] a);
    logic [15:0] v;
    v = ref_mem[a];
`ifdef ARRAY_MEM_A_WR_BYPASS_EN
    if (!rst && w_en && a == write_addr) v = write_data;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'(i);
  endtask

  task automatic set_reads(input logic [5:0] a0, a1, a2, a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  task automatic check_ports(input string tag);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("%s_p%0d", tag, k), rd[k], model_read(ra[k]));
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    w_en = 1'b1; write_addr = a; write_data = d;
    @(posedge clk);
    ref_mem[a] = d;
    #1 w_en = 1'b0; write_addr = 'x; write_data = 'x;
  endtask

  initial begin
    set_reads(0, 0, 0, 0);
    // Asynchronous reset, no clock edge needed for the pattern.
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 64; i += 4) begin
      set_reads(6'(i), 6'(i+1), 6'(i+2), 6'(i+3));
      #1;
      for (int k = 0; k < 4; k++) check("reset_pattern", rd[k], 16'(i+k));
    end
    @(negedge clk);
    rst = 1'b0;

    set_reads(1, 2, 3, 4);
    #1;
    for (int k = 0; k < 4; k++) check("rd_1234", rd[k], 16'(k+1));
    set_reads(5, 9, 13, 17);
    #1;
    check("rd_5", rd[0], 16'd5);  check("rd_9", rd[1], 16'd9);
    check("rd_13", rd[2], 16'd13); check("rd_17", rd[3], 16'd17);

    // Same-cycle write/read of address 20.
    @(negedge clk);
    set_reads(20, 21, 0, 63);
    w_en = 1'b1; write_addr = 20; write_data = 16'd42;
    #1;
`ifdef ARRAY_MEM_A_WR_BYPASS_EN
    check("pre_edge_20", rd[0], 16'd42);
`else
    check("pre_edge_20", rd[0], 16'd20);
`endif
    check("pre_edge_21", rd[1], 16'd21);
    @(posedge clk);
    ref_mem[20] = 16'd42;
    #1 w_en = 1'b0;
    check("post_edge_20", rd[0], 16'd42);

    do_write(63, 16'hBEEF);
    set_reads(63, 63, 63, 63);
    #1;
    for (int k = 0; k < 4; k++) check("rd_63", rd[k], 16'hBEEF);
    set_reads(0, 63, 0, 63);
    #1;
    check("rd_0", rd[0], 16'd0);

    // Back-to-back writes with w_en held.
    @(negedge clk);
    w_en = 1'b1; write_addr = 10; write_data = 16'hAAAA;
    @(posedge clk);
    #1 write_addr = 11; write_data = 16'h5555;
    @(posedge clk);
    #1 w_en = 1'b0;
    ref_mem[10] = 16'hAAAA; ref_mem[11] = 16'h5555;
    set_reads(10, 11, 10, 11);
    #1;
    check("b2b_10", rd[0], 16'hAAAA);
    check("b2b_11", rd[1], 16'h5555);

    // Async reset mid-operation, with a write attempted during reset.
    do_write(7, 16'h1234);
    set_reads(7, 20, 63, 10);
    #1 check("wr_7", rd[0], 16'h1234);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_7", rd[0], 16'd7);
    check("async_rst_63", rd[2], 16'd63);
    w_en = 1'b1; write_addr = 7; write_data = 16'hFFFF;
    @(posedge clk);
    #1 check("wr_during_rst_7", rd[0], 16'd7);
    w_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_7", rd[0], 16'd7);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      w_en = 1'($urandom_range(0, 1));
      write_addr = 6'($urandom);
      write_data = 16'($urandom);
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 3) == 0) ? write_addr : 6'($urandom);
      check_ports("rand");
      @(posedge clk);
      if (w_en) ref_mem[write_addr] = write_data;
    end
    @(negedge clk);
    w_en = 1'b0;

    // Sweep the whole array to confirm final contents.
    for (int i = 0; i < 64; i += 4) begin
      set_reads(6'(i), 6'(i+1), 6'(i+2), 6'(i+3));
      check_ports("sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
